uart_tx_fifo: RTL and testbench

Buffered UART transmitter for the memory-mapped I/O block. It accepts bytes over the existing go/bsy handshake used for the UART-out address. It queues up to 2^FIFO_DEPTH_BITWIDTH bytes and serializes them 8N1, LSB first, with no idle gap between queued frames. The CPU can therefore issue several `sb` writes to UART-out without stalling on each full frame time.

---
 rtl/uart_tx_fifo_if.sv | 22 ++
 rtl/uart_tx_fifo.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo_if
//  Description : Producer-side handshake bundle for the buffered UART
//                transmitter. The producer drives a byte and a go request;
//                the transmitter answers with bsy while the request is
//                pending.
//  Signals     : data [7:0]  byte to enqueue (producer -> transmitter)
//                go          enqueue request, held until bsy is seen low
//                bsy         request pending and not yet taken
//  Modports    : master (producer), slave (transmitter)
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_fifo_if;
   logic [7:0] data;
   logic       go;
   logic       bsy;

   modport master (output data, output go, input bsy);
   modport slave  (input data, input go, output bsy);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Buffered 8N1 UART transmitter. Bytes arrive over the go/bsy
//                handshake, are queued in a 2^FIFO_DEPTH_BITWIDTH entry FIFO
//                and are serialized LSB first with no idle gap between
//                queued frames.
//  Ports       : clk          single clock, rising edge
//                rst_n        asynchronous active-low reset
//                bus          go/data/bsy handshake (slave modport)
//                tx_o         registered serial line, idle high
//                empty_o      FIFO holds no bytes
//                full_o       FIFO holds DEPTH bytes
//                count_o      bytes queued, excluding the byte being shifted
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int CLK_FREQ            = 50_000_000,
   parameter int BAUD_RATE           = 9600,
   parameter int FIFO_DEPTH_BITWIDTH = 2
) (
   input  wire logic                         clk,
   input  wire logic                         rst_n,
   uart_tx_fifo_if.slave                     bus,
   output logic                              tx_o,
   output logic                              empty_o,
   output logic                              full_o,
   output logic [FIFO_DEPTH_BITWIDTH:0]      count_o
);

   localparam int c_bit_time = CLK_FREQ / BAUD_RATE;
   localparam int c_depth    = 1 << FIFO_DEPTH_BITWIDTH;
   localparam int c_bc_w     = (c_bit_time > 1) ? $clog2(c_bit_time) : 1;

   localparam logic [c_bc_w-1:0]              c_bit_last = c_bc_w'(c_bit_time - 1);
   localparam logic [c_bc_w-1:0]              c_bc_one   = c_bc_w'(1);
   localparam logic [FIFO_DEPTH_BITWIDTH:0]   c_cnt_full = (FIFO_DEPTH_BITWIDTH + 1)'(c_depth);
   localparam logic [FIFO_DEPTH_BITWIDTH:0]   c_cnt_one  = (FIFO_DEPTH_BITWIDTH + 1)'(1);
   localparam logic [FIFO_DEPTH_BITWIDTH-1:0] c_ptr_one  = FIFO_DEPTH_BITWIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Storage and state
   // ------------------------------------------------------------------
   logic [7:0]                     mem_q [c_depth];
   logic [FIFO_DEPTH_BITWIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_DEPTH_BITWIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_DEPTH_BITWIDTH:0]   count_q,  count_d;
   logic                           accepted_q, accepted_d;

   state_t                         state_q, state_d;
   logic [c_bc_w-1:0]              bit_cnt_q, bit_cnt_d;
   logic [2:0]                     bit_ix_q, bit_ix_d;
   logic [7:0]                     shift_q, shift_d;
   logic                           tx_q, tx_d;

   logic                           w_empty;
   logic                           w_full;
   logic                           w_push;
   logic                           w_pop;

   assign w_empty = (count_q == '0);
   assign w_full  = (count_q == c_cnt_full);

   // Push uses the registered full flag, so a pop on the same edge cannot
   // make room for the pending request; it lands one edge later.
   assign w_push  = bus.go & ~accepted_q & ~w_full;

   // bsy is purely combinational so the producer sees it in the request
   // cycle; reset forces it low.
   assign bus.bsy = rst_n & bus.go & ~accepted_q;

   assign tx_o    = tx_q;
   assign empty_o = w_empty;
   assign full_o  = w_full;
   assign count_o = count_q;

   // ------------------------------------------------------------------
   // FIFO bookkeeping
   // ------------------------------------------------------------------
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      accepted_d = accepted_q;

      if (w_push) begin
         wr_ptr_d = wr_ptr_q + c_ptr_one;
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + c_ptr_one;
      end

      unique case ({w_push, w_pop})
         2'b10:   count_d = count_q + c_cnt_one;
         2'b01:   count_d = count_q - c_cnt_one;
         default: count_d = count_q;
      endcase

      // One enqueue per request: accepted stays set until go is released.
      if (!bus.go) begin
         accepted_d = 1'b0;
      end else if (w_push) begin
         accepted_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= bus.data;
      end
   end

   // ------------------------------------------------------------------
   // Serializer next state. tx_d is computed for the state being entered
   // so the line changes on the same edge as the state.
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      bit_ix_d  = bit_ix_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      w_pop     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (!w_empty) begin
               w_pop     = 1'b1;
               shift_d   = mem_q[rd_ptr_q];
               bit_cnt_d = c_bit_last;
               state_d   = S_START;
               tx_d      = 1'b0;
            end
         end

         S_START: begin
            if (bit_cnt_q == '0) begin
               bit_cnt_d = c_bit_last;
               bit_ix_d  = 3'd0;
               state_d   = S_DATA;
               tx_d      = shift_q[0];
            end else begin
               bit_cnt_d = bit_cnt_q - c_bc_one;
            end
         end

         S_DATA: begin
            if (bit_cnt_q == '0) begin
               bit_cnt_d = c_bit_last;
               if (bit_ix_q == 3'd7) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  // Shift at the end of each bit; the next bit is shift[1].
                  shift_d  = shift_q >> 1;
                  bit_ix_d = bit_ix_q + 3'd1;
                  tx_d     = shift_q[1];
               end
            end else begin
               bit_cnt_d = bit_cnt_q - c_bc_one;
            end
         end

         S_STOP: begin
            if (bit_cnt_q == '0) begin
               if (!w_empty) begin
                  // Back-to-back frame: stop bit runs straight into start.
                  w_pop     = 1'b1;
                  shift_d   = mem_q[rd_ptr_q];
                  bit_cnt_d = c_bit_last;
                  state_d   = S_START;
                  tx_d      = 1'b0;
               end else begin
                  state_d = S_IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q - c_bc_one;
            end
         end

         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         accepted_q <= 1'b0;
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         bit_ix_q   <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         accepted_q <= accepted_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         bit_ix_q   <= bit_ix_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Self-checking bench for uart_tx_fifo. Requested bytes are
//                queued as expected frames; a line monitor decodes tx and
//                compares each received frame with the queue head.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;
   localparam int CLK_FREQ  = 40;
   localparam int BAUD_RATE = 10;
   localparam int FDB       = 2;
   localparam int BT        = CLK_FREQ / BAUD_RATE;
   localparam int FRAME     = 10 * BT;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           tx, empty, full;
   logic [FDB:0]   count;

   uart_tx_fifo_if bus ();

   uart_tx_fifo #(
      .CLK_FREQ            (CLK_FREQ),
      .BAUD_RATE           (BAUD_RATE),
      .FIFO_DEPTH_BITWIDTH (FDB)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus.slave),
      .tx_o    (tx),
      .empty_o (empty),
      .full_o  (full),
      .count_o (count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] exp_q[$];
   int         starts[$];
   int         frames_done = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Line monitor: a low tx while idle starts a frame; every cycle of the
   // 10-bit frame is compared with the expected start/data/stop pattern.
   initial begin : monitor
      logic [7:0] b;
      logic [9:0] fr;
      logic [9:0] rx;
      int         bad;
      logic       aborted;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx === 1'b0) begin
            starts.push_back(cyc);
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", 32'd1, 32'd0);
               repeat (FRAME - 1) @(negedge clk);
            end else begin
               b       = exp_q.pop_front();
               fr      = {1'b1, b, 1'b0};
               rx      = '0;
               bad     = 0;
               aborted = 1'b0;
               for (int i = 0; i < FRAME; i++) begin
                  if (i > 0) @(negedge clk);
                  if (rst_n !== 1'b1) begin
                     aborted = 1'b1;
                     break;
                  end
                  if (tx !== fr[i / BT]) bad++;
                  if (i % BT == 1) rx[i / BT] = tx;
               end
               if (!aborted) begin
                  chk("frame_bits", 32'(rx), 32'(fr));
                  chk("bit_hold", 32'(bad), 32'd0);
                  frames_done++;
               end
            end
         end
      end
   end

   // Issue one request; returns the cycle in which bsy was first seen low,
   // how many cycles bsy stayed high, and count at that moment.
   task automatic send(input logic [7:0] b, input int hold,
                       output int acc_cyc, output int waits, output int cnt_acc);
      @(negedge clk);
      bus.data = b;
      bus.go   = 1'b1;
      exp_q.push_back(b);
      #1 chk("bsy_on_request", 32'(bus.bsy), 32'd1);
      waits = 0;
      forever begin
         @(negedge clk);
         waits++;
         if (bus.bsy === 1'b0) break;
         if (waits > 400) begin
            chk("accept_timeout", 32'd1, 32'd0);
            break;
         end
      end
      acc_cyc = cyc;
      cnt_acc = int'(count);
      repeat (hold) @(negedge clk);
      bus.go = 1'b0;
   endtask

   task automatic wait_frames(input int target, input string name);
      int t = 0;
      while (frames_done < target && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk(name, 32'(frames_done), 32'(target));
   endtask

   initial begin : stim
      int a, w, c, n0, s0, t;
      bus.go   = 1'b0;
      bus.data = 8'h00;
      rst_n    = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_tx",    32'(tx),      32'd1);
      chk("reset_empty", 32'(empty),   32'd1);
      chk("reset_full",  32'(full),    32'd0);
      chk("reset_count", 32'(count),   32'd0);
      chk("reset_bsy",   32'(bus.bsy), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Single byte
      n0 = frames_done;
      send(8'hA5, 0, a, w, c);
      chk("single_bsy_cycles", 32'(w), 32'd1);
      chk("single_count", 32'(c), 32'd1);
      wait_frames(n0 + 1, "single_frames");
      chk("single_latency", 32'(starts[starts.size() - 1] - a), 32'd1);
      @(negedge clk);
      chk("single_idle_tx", 32'(tx), 32'd1);
      chk("single_empty", 32'(empty), 32'd1);

      // Held go
      n0 = frames_done;
      send(8'($urandom), 20, a, w, c);
      chk("held_count", 32'(c), 32'd1);
      repeat (60) @(negedge clk);
      chk("held_frames", 32'(frames_done - n0), 32'd1);
      chk("held_count_after", 32'(count), 32'd0);
      chk("held_queue", 32'(exp_q.size()), 32'd0);

      // Fill and stall
      n0 = frames_done;
      s0 = starts.size();
      for (int i = 1; i <= 5; i++) send(8'(i), 0, a, w, c);
      @(negedge clk);
      chk("fill_count", 32'(count), 32'd4);
      chk("fill_full", 32'(full), 32'd1);
      send(8'h06, 0, a, w, c);
      chk("fill_accept_edge", 32'(a - starts[s0 + 1]), 32'd1);
      chk("fill_count_after", 32'(c), 32'd4);
      wait_frames(n0 + 6, "fill_frames");
      for (int k = 1; k < 6; k++)
         chk("fill_contiguous", 32'(starts[s0 + k] - starts[s0 + k - 1]), 32'(FRAME));

      // Wrap-around
      n0 = frames_done;
      for (int i = 0; i < 10; i++) begin
         send(8'($urandom), 0, a, w, c);
         repeat (48) @(negedge clk);
      end
      wait_frames(n0 + 10, "wrap_frames");
      chk("wrap_queue", 32'(exp_q.size()), 32'd0);

      // Random gaps, including back-to-back bursts that hit full
      n0 = frames_done;
      for (int i = 0; i < 12; i++) begin
         send(8'($urandom), 0, a, w, c);
         repeat ($urandom_range(0, 60)) @(negedge clk);
      end
      wait_frames(n0 + 12, "random_frames");
      chk("random_queue", 32'(exp_q.size()), 32'd0);

      // Reset mid-frame with two bytes queued
      s0 = starts.size();
      for (int i = 0; i < 3; i++) send(8'($urandom), 0, a, w, c);
      t = 0;
      while ((starts.size() <= s0 || cyc < starts[s0] + 15) && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("pre_reset_count", 32'(count), 32'd2);
      #2;
      rst_n  = 1'b0;
      bus.go = 1'b1;
      #1;
      chk("midreset_tx",    32'(tx),      32'd1);
      chk("midreset_count", 32'(count),   32'd0);
      chk("midreset_empty", 32'(empty),   32'd1);
      chk("midreset_full",  32'(full),    32'd0);
      chk("midreset_bsy",   32'(bus.bsy), 32'd0);
      exp_q.delete();
      @(negedge clk);
      bus.go = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n0 = frames_done;
      repeat (100) @(negedge clk);
      chk("post_reset_silent", 32'(frames_done - n0), 32'd0);
      chk("post_reset_tx", 32'(tx), 32'd1);
      send(8'h3C, 0, a, w, c);
      wait_frames(n0 + 1, "post_reset_frame");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
